// File: rtl/tpu_pkg.sv
// Shared types and int8 helpers for the TPU datapath blocks.
package tpu_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_CLAMP = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    function automatic logic signed [7:0] sat_int8(input logic signed [31:0] v);
        logic signed [7:0] r;
        if (v > 32'(INT8_MAX)) begin
            r = 8'(INT8_MAX);
        end else if (v < 32'(INT8_MIN)) begin
            r = 8'(INT8_MIN);
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word; a push while full is accepted
// only when the head is popped on the same edge, otherwise the caller sees full.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_en;
    logic             push_en;
    logic [CW-1:0]    remain;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign head_data = head_q;

    always_comb begin
        pop_en   = pop && !empty;
        push_en  = push && (!full || pop_en);
        remain   = count_q - CW'(pop_en);
        count_d  = remain + CW'(push_en);
        rd_ptr_d = pop_en  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        // The head is the pushed word itself when nothing else survives the pop.
        if (count_d == '0) begin
            head_d = '0;
        end else if (remain == '0) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/act_quant_packer.sv
// Activation + int8 saturation of the normalizer stream, packing four results
// per 32-bit word into a FIFO; overflow is flagged since upstream cannot stall.
module act_quant_packer
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  act_mode,
    input  logic [7:0]  relu_cap,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_mask,
    output logic        overflow
);

    function automatic logic signed [7:0] act_quant(input logic signed [31:0] x,
                                                    input act_mode_e      mode,
                                                    input logic [6:0]     cap);
        logic signed [31:0] v;
        logic signed [31:0] ceil;
        v    = x;
        ceil = $signed({25'd0, cap});
        case (mode)
            ACT_RELU: begin
                if (x < 0) v = '0;
            end
            ACT_CLAMP: begin
                if (x < 0) v = '0;
                else if (x > ceil) v = ceil;
            end
            default: v = x;
        endcase
        return sat_int8(v);
    endfunction

    logic signed [7:0] s1_byte_q, s1_byte_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_flush_q, s1_flush_d;

    logic [2:0][7:0]   lane_q, lane_d;
    logic [1:0]        lane_cnt_q, lane_cnt_d;
    logic              overflow_q, overflow_d;

    logic [2:0]        fill;
    logic              pack_push;
    logic [31:0]       pack_word;
    logic [3:0]        pack_mask;

    logic [35:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    // S1: activation and saturation
    always_comb begin
        s1_byte_d  = act_quant($signed(data_in), act_mode_e'(act_mode), relu_cap[6:0]);
        s1_valid_d = valid_in;
        s1_flush_d = flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_flush_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_flush_q <= s1_flush_d;
        end
        s1_byte_q <= s1_byte_d;
    end

    // S2: lane packing
    always_comb begin
        lane_d     = lane_q;
        lane_cnt_d = lane_cnt_q;
        pack_push  = 1'b0;
        pack_word  = '0;
        fill       = {1'b0, lane_cnt_q} + {2'b00, s1_valid_q};
        pack_mask  = 4'((5'd1 << fill) - 5'd1);

        if (s1_valid_q && lane_cnt_q != 2'd3) begin
            lane_d[lane_cnt_q] = s1_byte_q;
        end

        // Lanes at or above the fill point stay zero in a partial word.
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane_cnt_q) begin
                pack_word[8*i +: 8] = lane_q[i];
            end else if (2'(i) == lane_cnt_q && s1_valid_q) begin
                pack_word[8*i +: 8] = s1_byte_q;
            end
        end
        if (lane_cnt_q == 2'd3 && s1_valid_q) begin
            pack_word[31:24] = s1_byte_q;
        end

        if ((s1_valid_q && lane_cnt_q == 2'd3) || (s1_flush_q && fill != 3'd0)) begin
            pack_push  = 1'b1;
            lane_cnt_d = 2'd0;
        end else if (s1_valid_q) begin
            lane_cnt_d = lane_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_cnt_q <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            overflow_q <= overflow_d;
        end
        lane_q <= lane_d;
    end

    // FIFO toward writeback
    assign fifo_pop = out_ready && !fifo_empty;

    always_comb begin
        overflow_d = overflow_q | (pack_push && fifo_full && !fifo_pop);
    end

    sync_fifo #(
        .WIDTH (36),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pack_push),
        .push_data ({pack_mask, pack_word}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[31:0];
    assign out_mask  = fifo_head[35:32];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_act_quant_packer.sv
// Bench for act_quant_packer: queue-level reference model checked every cycle,
// plus directed words with hand-computed values.
module tb_act_quant_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] data_in;
    logic [1:0]  act_mode;
    logic [7:0]  relu_cap;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_mask;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    act_quant_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .act_mode  (act_mode),
        .relu_cap  (relu_cap),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_act(input int x, input int mode, input int cap);
        int v;
        v = x;
        if (mode == 1 && v < 0) v = 0;
        if (mode == 2) begin
            if (v < 0) v = 0;
            if (v > (cap & 127)) v = cap & 127;
        end
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    // Reference model: list of bytes awaiting packing, list of queued words.
    logic [35:0] mq[$];
    logic [7:0]  pend[$];
    bit          m_ovf = 0;
    bit          s1v = 0, s1f = 0;
    logic [7:0]  s1b = '0;
    bit          started = 0;

    task automatic model_step();
        logic [31:0] w;
        int          n;
        started = 1;
        if (reset) begin
            mq.delete();
            pend.delete();
            m_ovf = 0;
            s1v = 0;
            s1f = 0;
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (s1v) pend.push_back(s1b);
            n = pend.size();
            if (n == 4 || (s1f && n > 0)) begin
                w = '0;
                for (int i = 0; i < n; i++) w[8*i +: 8] = pend[i];
                if (mq.size() < DEPTH) mq.push_back({4'((1 << n) - 1), w});
                else m_ovf = 1;
                pend.delete();
            end
            s1v = valid_in;
            s1f = flush;
            s1b = ref_act($signed(data_in), int'(act_mode), int'(relu_cap));
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", 36'(out_valid), 36'(mq.size() != 0));
            chk("overflow", 36'(overflow), 36'(m_ovf));
            if (mq.size() != 0) chk("head_word", {out_mask, out_data}, mq[0]);
        end
    end

    task automatic drv(input bit v, input int d, input bit f);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(negedge clk);
    endtask

    task automatic expect_word(input string name, input logic [31:0] d, input logic [3:0] m);
        chk({name, "_valid"}, 36'(out_valid), 36'(1));
        chk({name, "_data"}, 36'(out_data), 36'(d));
        chk({name, "_mask"}, 36'(out_mask), 36'(m));
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = '0;
        act_mode  = 2'd0;
        relu_cap  = 8'd0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 36'(out_valid), 36'(0));
        chk("rst_data", 36'(out_data), 36'(0));
        chk("rst_mask", 36'(out_mask), 36'(0));
        chk("rst_ovf", 36'(overflow), 36'(0));
        reset = 1'b0;

        // Mode 0 saturation, latency t+2
        drv(1, 300, 0); drv(1, -300, 0); drv(1, 5, 0); drv(1, -5, 0);
        chk("lat_t1", 36'(out_valid), 36'(0));
        drv(0, 0, 0);
        expect_word("sat", 32'hFB05807F, 4'hF);
        drv(0, 0, 0);

        act_mode = 2'd1;
        drv(1, -7, 0); drv(1, 9, 0); drv(1, 0, 0); drv(1, 200, 0);
        drv(0, 0, 0);
        expect_word("relu", 32'h7F000900, 4'hF);
        drv(0, 0, 0);

        act_mode = 2'd2;
        relu_cap = 8'hFA;
        drv(1, 130, 0); drv(1, -1, 0); drv(1, 50, 0); drv(1, 32'h7A, 0);
        drv(0, 0, 0);
        expect_word("clamp", 32'h7A32007A, 4'hF);
        drv(0, 0, 0);

        act_mode = 2'd0;
        drv(1, 1, 0); drv(1, 2, 0); drv(0, 0, 1);
        drv(0, 0, 0);
        expect_word("flush2", 32'h00000201, 4'h3);
        drv(0, 0, 0);

        drv(1, 1, 0); drv(1, 2, 0); drv(1, 3, 1);
        drv(0, 0, 0);
        expect_word("flush3", 32'h00030201, 4'h7);
        drv(0, 0, 0);

        drv(0, 0, 1); drv(0, 0, 0); drv(0, 0, 0);
        chk("flush_empty", 36'(out_valid), 36'(0));

        // Backpressure: one word more than the FIFO holds
        out_ready = 1'b0;
        for (int i = 0; i < 4 * (DEPTH + 1); i++) drv(1, i, 0);
        drv(0, 0, 0);
        chk("ovf_set", 36'(overflow), 36'(1));
        expect_word("ovf_head", 32'h03020100, 4'hF);
        drv(0, 0, 0);
        expect_word("ovf_hold", 32'h03020100, 4'hF);
        out_ready = 1'b1;
        repeat (DEPTH + 2) drv(0, 0, 0);
        chk("drained", 36'(out_valid), 36'(0));
        chk("ovf_sticky", 36'(overflow), 36'(1));

        reset = 1'b1;
        drv(0, 0, 0);
        reset = 1'b0;
        chk("ovf_cleared", 36'(overflow), 36'(0));

        // Full FIFO with a pop on the edge the fifth word is pushed
        out_ready = 1'b0;
        for (int i = 0; i < 4 * (DEPTH + 1); i++) drv(1, 32 + i, 0);
        out_ready = 1'b1;
        drv(0, 0, 0);
        out_ready = 1'b0;
        drv(0, 0, 0);
        chk("pushpop_ovf", 36'(overflow), 36'(0));
        expect_word("pushpop_head", 32'h27262524, 4'hF);
        out_ready = 1'b1;
        repeat (DEPTH + 2) drv(0, 0, 0);

        // Reset mid-word
        drv(1, 7, 0); drv(1, 8, 0); drv(1, 9, 0);
        reset = 1'b1;
        drv(0, 0, 0);
        reset = 1'b0;
        drv(0, 0, 0); drv(0, 0, 0);
        chk("rst_mid_none", 36'(out_valid), 36'(0));
        drv(1, 10, 0); drv(1, 11, 0); drv(1, 12, 0); drv(1, 13, 0);
        drv(0, 0, 0);
        expect_word("rst_mid_word", 32'h0D0C0B0A, 4'hF);
        drv(0, 0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            int d;
            act_mode  = 2'($urandom_range(0, 3));
            relu_cap  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: d = int'($urandom_range(0, 400)) - 200;
                1: d = int'($urandom);
                default: d = int'($urandom_range(0, 255)) - 128;
            endcase
            drv($urandom_range(0, 4) != 0, d, $urandom_range(0, 7) == 0);
        end
        out_ready = 1'b1;
        repeat (DEPTH + 4) drv(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
